array_scan_ctrl: RTL and testbench

Scan controller for a two-dimensional unpacked array of packed multi-lane words. Elements are loaded through a write port; `start` then streams them out over a valid/ready interface. Rows, columns and (optionally) packed lanes are visited in descending index order, the same order as `foreach` over descending ranges. The block is the sequencer between a configuration or load source and any consumer that needs the array contents serialised with their indices.

---
 rtl/array_scan_pkg.sv | 19 +
 rtl/array_index_walker.sv | 47 ++++
 rtl/array_scan_ctrl.sv | 107 ++++++++++
 tb/tb_array_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_scan_pkg.sv
// array_scan_pkg: shared state/mode types and index-width helper for the array scan controller
package array_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_e;

    typedef enum logic {
        ELEM = 1'b0,
        LANE = 1'b1
    } scan_mode_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_index_walker.sv
// array_index_walker: nested descending row/column/lane counter, lane step first when enabled
module array_index_walker #(
    parameter int ROWS  = 3,
    parameter int COLS  = 2,
    parameter int LANES = 2,
    parameter int RW    = 2,
    parameter int CW    = 1,
    parameter int LNW   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           adv,
    input  logic           lane_en,
    output logic [RW-1:0]  row,
    output logic [CW-1:0]  col,
    output logic [LNW-1:0] lane,
    output logic           last
);

    logic [LNW-1:0] lane_top;

    assign lane_top = lane_en ? LNW'(LANES - 1) : '0;
    assign last     = (row == '0) && (col == '0) && (!lane_en || lane == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            row  <= '0;
            col  <= '0;
            lane <= '0;
        end else if (load) begin
            row  <= RW'(ROWS - 1);
            col  <= CW'(COLS - 1);
            lane <= lane_top;
        end else if (adv) begin
            if (lane_en && lane != '0) begin
                lane <= lane - LNW'(1);
            end else begin
                lane <= lane_top;
                col  <= (col == '0) ? CW'(COLS - 1) : col - CW'(1);
                if (col == '0)
                    row <= (row == '0) ? RW'(ROWS - 1) : row - RW'(1);
            end
        end
    end

endmodule

// File: rtl/array_scan_ctrl.sv
// array_scan_ctrl: loads a 2-D array of multi-lane words and streams it out in descending index order
module array_scan_ctrl
    import array_scan_pkg::*;
#(
    parameter int ROWS  = 3,
    parameter int COLS  = 2,
    parameter int LANES = 2,
    parameter int LW    = 4,
    localparam int EW   = LANES * LW,
    localparam int RW   = idx_w(ROWS),
    localparam int CW   = idx_w(COLS),
    localparam int LNW  = idx_w(LANES)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [RW-1:0]  wr_row,
    input  logic [CW-1:0]  wr_col,
    input  logic [EW-1:0]  wr_data,
    input  logic           start,
    input  logic           mode,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RW-1:0]  out_row,
    output logic [CW-1:0]  out_col,
    output logic [LNW-1:0] out_lane,
    output logic [EW-1:0]  out_data,
    output logic           out_last,
    output logic           done
);

    logic [LANES-1:0][LW-1:0] mem [ROWS-1:0][COLS-1:0];
    logic [LANES-1:0][LW-1:0] sel;
    scan_state_e              state_q, state_d;
    scan_mode_e               mode_q;
    logic                     load, adv, lane_en, last, wr_ok;

    assign wr_ok = (state_q == IDLE) && wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[r][c] <= '0;
        end else if (wr_ok) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= ELEM;
        end else begin
            state_q <= state_d;
            if (load)
                mode_q <= scan_mode_e'(mode);
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        if (state_q == IDLE && start) begin
            load    = 1'b1;
            state_d = SCAN;
        end
        if (state_q == SCAN && out_ready) begin
            adv     = !last;
            state_d = last ? DONE : SCAN;
        end
        if (state_q == DONE)
            state_d = IDLE;
    end

    // The load uses the incoming mode; during the scan the latched mode rules.
    assign lane_en = (state_q == IDLE) ? mode : (mode_q == LANE);

    array_index_walker #(
        .ROWS (ROWS),
        .COLS (COLS),
        .LANES(LANES),
        .RW   (RW),
        .CW   (CW),
        .LNW  (LNW)
    ) u_walker (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .adv    (adv),
        .lane_en(lane_en),
        .row    (out_row),
        .col    (out_col),
        .lane   (out_lane),
        .last   (last)
    );

    assign sel       = mem[out_row][out_col];
    assign out_data  = (mode_q == LANE) ? EW'(sel[out_lane]) : sel;
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == SCAN);
    assign out_last  = out_valid && last;
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_array_scan_ctrl.sv
// tb_array_scan_ctrl: scoreboard bench for array_scan_ctrl at default parameters
module tb_array_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_row = '0;
    logic       wr_col = 1'b0;
    logic [7:0] wr_data = '0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       out_ready = 1'b0;
    logic       busy, out_valid, out_last, done;
    logic [1:0] out_row;
    logic       out_col, out_lane;
    logic [7:0] out_data;

    int tests = 0;
    int failed = 0;

    logic [7:0] model [3][2];

    typedef struct packed {
        logic [1:0] row;
        logic       col;
        logic       lane;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t sb[$];

    array_scan_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .start    (start),
        .mode     (mode),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_col  (out_col),
        .out_lane (out_lane),
        .out_data (out_data),
        .out_last (out_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int r, input int c, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_row  = 2'(r);
        wr_col  = 1'(c);
        wr_data = d;
        tick();
        wr_en = 1'b0;
        if (r < 3 && c < 2)
            model[r][c] = d;
    endtask

    task automatic push_scan(input logic m);
        beat_t e;
        for (int r = 2; r >= 0; r--)
            for (int c = 1; c >= 0; c--)
                for (int k = (m ? 1 : 0); k >= 0; k--) begin
                    e.row  = 2'(r);
                    e.col  = 1'(c);
                    e.lane = 1'(k);
                    e.data = m ? {4'h0, model[r][c][k*4 +: 4]} : model[r][c];
                    e.last = (r == 0 && c == 0 && k == 0);
                    sb.push_back(e);
                end
    endtask

    task automatic start_scan(input logic m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input int stall_beat, input int stall_len, input int inject_beat);
        int    b = 0;
        int    held = 0;
        int    guard = 0;
        bit    inj = 1'b0;
        beat_t e;
        while (sb.size() > 0 && guard < 100) begin
            guard++;
            e = sb[0];
            wr_en = 1'b0;
            start = 1'b0;
            tests++;
            if (out_valid !== 1'b1) begin
                failed++;
                $display("FAIL valid beat %0d: got %b want 1", b, out_valid);
            end
            tests++;
            if ({out_row, out_col, out_lane, out_data, out_last} !== {e.row, e.col, e.lane, e.data, e.last}) begin
                failed++;
                $display("FAIL beat %0d: got row=%0d col=%0d lane=%0d data=%h last=%b want row=%0d col=%0d lane=%0d data=%h last=%b",
                         b, out_row, out_col, out_lane, out_data, out_last, e.row, e.col, e.lane, e.data, e.last);
            end
            if (b == inject_beat && !inj) begin
                inj     = 1'b1;
                wr_en   = 1'b1;
                wr_row  = 2'd1;
                wr_col  = 1'b1;
                wr_data = 8'hFF;
                start   = 1'b1;
                mode    = 1'b1;
            end
            if (b == stall_beat && held < stall_len) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = 1'b1;
                void'(sb.pop_front());
                b++;
            end
            tick();
        end
        wr_en = 1'b0;
        start = 1'b0;
        if (sb.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain timeout: %0d beats left want 0", sb.size());
            sb.delete();
        end
        tests++;
        if ({done, busy, out_valid} !== 3'b110) begin
            failed++;
            $display("FAIL done cycle: got done=%b busy=%b valid=%b want 1 1 0", done, busy, out_valid);
        end
        tick();
        tests++;
        if ({done, busy} !== 2'b00) begin
            failed++;
            $display("FAIL after done: got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                model[r][c] = 8'h00;
        rst = 1'b1;
        tick();
        tick();
        tests++;
        if ({busy, out_valid, out_last, done} !== 4'b0000) begin
            failed++;
            $display("FAIL reset flags: got %b want 0000", {busy, out_valid, out_last, done});
        end
        tests++;
        if ({out_row, out_col, out_lane} !== 4'b0000) begin
            failed++;
            $display("FAIL reset idx: got %b want 0000", {out_row, out_col, out_lane});
        end
        tests++;
        if (out_data !== 8'h00) begin
            failed++;
            $display("FAIL reset data: got %h want 00", out_data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_elem;
        wr(2, 1, 8'h05);
        wr(2, 0, 8'h01);
        wr(1, 1, 8'h10);
        wr(1, 0, 8'h02);
        wr(0, 1, 8'h15);
        wr(0, 0, 8'h03);
        push_scan(1'b0);
        out_ready = 1'b1;
        start_scan(1'b0);
        drain(-1, 0, -1);
    endtask

    task automatic test_lane;
        wr(2, 1, 8'hA5);
        push_scan(1'b1);
        start_scan(1'b1);
        drain(-1, 0, -1);
    endtask

    task automatic test_backpressure;
        push_scan(1'b0);
        start_scan(1'b0);
        drain(1, 3, -1);
    endtask

    task automatic test_busy_ignore;
        push_scan(1'b0);
        start_scan(1'b0);
        drain(-1, 0, 1);
        push_scan(1'b0);
        start_scan(1'b0);
        drain(-1, 0, -1);
    endtask

    task automatic test_oob_and_start_write;
        wr(3, 0, 8'hEE);
        wr_en   = 1'b1;
        wr_row  = 2'd2;
        wr_col  = 1'b1;
        wr_data = 8'h77;
        model[2][1] = 8'h77;
        push_scan(1'b0);
        start_scan(1'b0);
        wr_en = 1'b0;
        drain(-1, 0, -1);
    endtask

    task automatic test_rst_mid_scan;
        out_ready = 1'b1;
        start_scan(1'b0);
        tick();
        tick();
        tick();
        tests++;
        if ({out_valid, out_row, out_col} !== {1'b1, 2'd1, 1'b0}) begin
            failed++;
            $display("FAIL 4th beat idx: got valid=%b row=%0d col=%0d want 1 1 0", out_valid, out_row, out_col);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if ({busy, out_valid, done} !== 3'b000) begin
            failed++;
            $display("FAIL rst abort flags: got busy=%b valid=%b done=%b want 0 0 0", busy, out_valid, done);
        end
        tests++;
        if ({out_row, out_col, out_data} !== 11'd0) begin
            failed++;
            $display("FAIL rst abort outs: got row=%0d col=%0d data=%h want 0 0 00", out_row, out_col, out_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (done !== 1'b0) begin
                failed++;
                $display("FAIL rst no done: cycle %0d got %b want 0", i, done);
            end
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                model[r][c] = 8'h00;
        push_scan(1'b1);
        start_scan(1'b1);
        drain(-1, 0, -1);
    endtask

    initial begin
        test_reset();
        test_elem();
        test_lane();
        test_backpressure();
        test_busy_ignore();
        test_oob_and_start_write();
        test_rst_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
